// File: rtl/wb_debug_master.sv
// ============================================================================
// Module  : wb_debug_master
// Purpose : UART byte-stream command bridge acting as a Wishbone classic initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_debug_master #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] CMD_READ       = 8'h01,
  parameter logic [7:0] CMD_WRITE      = 8'h02
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  output logic        busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_tmo_last =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] c_st_ack = 8'h00;
  localparam logic [7:0] c_st_err = 8'h01;
  localparam logic [7:0] c_st_rty = 8'h02;
  localparam logic [7:0] c_st_tmo = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ADDR        = 3'd1,
    ST_WDATA       = 3'd2,
    ST_BUS         = 3'd3,
    ST_RESP_STATUS = 3'd4,
    ST_RESP_DATA   = 3'd5
  } state_t;

  state_t           r_state;
  logic             r_we;
  logic [31:0]      r_adr;
  logic [31:0]      r_wdat;
  logic [31:0]      r_rdat;
  logic [1:0]       r_byte_cnt;
  logic [CNT_W-1:0] r_tmo;
  logic             r_cyc;
  logic             r_busy;
  logic             r_rx_ready;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_tmo_hit;

  assign w_rx_fire = r_rx_ready & rx_valid_i;
  assign w_tx_fire = r_tx_valid & tx_ready_i;
  assign w_tmo_hit = (TIMEOUT_CYCLES > 0) && (r_tmo == c_tmo_last);

  assign rx_ready_o = r_rx_ready;
  assign tx_valid_o = r_tx_valid;
  assign tx_data_o  = r_tx_data;
  assign cyc_o      = r_cyc;
  assign stb_o      = r_cyc;
  assign sel_o      = r_cyc ? 4'hF : 4'h0;
  assign we_o       = r_cyc & r_we;
  assign adr_o      = r_adr;
  assign dat_o      = r_wdat;
  assign busy_o     = r_busy;

  // Handshake flags are registered alongside the state so every output is a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_adr      <= 32'h0;
      r_wdat     <= 32'h0;
      r_rdat     <= 32'h0;
      r_byte_cnt <= 2'd0;
      r_tmo      <= '0;
      r_cyc      <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rx_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (w_rx_fire) begin
            if (rx_data_i == CMD_READ || rx_data_i == CMD_WRITE) begin
              r_we       <= (rx_data_i == CMD_WRITE);
              r_byte_cnt <= 2'd0;
              r_busy     <= 1'b1;
              r_state    <= ST_ADDR;
            end
          end
        end

        ST_ADDR: begin
          if (w_rx_fire) begin
            r_adr      <= {rx_data_i, r_adr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_we) begin
                r_state <= ST_WDATA;
              end else begin
                r_rx_ready <= 1'b0;
                r_cyc      <= 1'b1;
                r_tmo      <= '0;
                r_state    <= ST_BUS;
              end
            end
          end
        end

        ST_WDATA: begin
          if (w_rx_fire) begin
            r_wdat     <= {rx_data_i, r_wdat[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_rx_ready <= 1'b0;
              r_cyc      <= 1'b1;
              r_tmo      <= '0;
              r_state    <= ST_BUS;
            end
          end
        end

        ST_BUS: begin
          // Any termination outranks a timeout landing in the same cycle.
          if (err_i || ack_i || rty_i || w_tmo_hit) begin
            r_cyc      <= 1'b0;
            r_tx_valid <= 1'b1;
            r_state    <= ST_RESP_STATUS;
            if (err_i) begin
              r_tx_data <= c_st_err;
            end else if (ack_i) begin
              r_tx_data <= c_st_ack;
              if (!r_we) begin
                r_rdat <= dat_i;
              end
            end else if (rty_i) begin
              r_tx_data <= c_st_rty;
            end else begin
              r_tx_data <= c_st_tmo;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_RESP_STATUS: begin
          if (w_tx_fire) begin
            if (!r_we && r_tx_data == c_st_ack) begin
              r_tx_data  <= r_rdat[7:0];
              r_rdat     <= {8'h00, r_rdat[31:8]};
              r_byte_cnt <= 2'd0;
              r_state    <= ST_RESP_DATA;
            end else begin
              r_tx_valid <= 1'b0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        ST_RESP_DATA: begin
          if (w_tx_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_tx_data <= r_rdat[7:0];
              r_rdat    <= {8'h00, r_rdat[31:8]};
            end
          end
        end

        default: begin
          r_cyc      <= 1'b0;
          r_tx_valid <= 1'b0;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_debug_master.sv
// ============================================================================
// Module  : tb_wb_debug_master
// Purpose : Directed self-checking bench for wb_debug_master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_debug_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  wb_debug_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .sel_o(sel_o),
    .dat_o(dat_o), .we_o(we_o), .dat_i(dat_i),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("rx_ready_wait", 32'(rx_ready_o), 32'h1);
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(tx_valid_o), 32'h1);
    chk(tag, 32'(tx_data_o), 32'(exp));
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8]);
  endtask

  // Entered in the first BUS cycle: ws wait states then one termination cycle.
  task automatic bus_term(input string tag, input int ws, input logic a, input logic e,
                          input logic r, input logic [31:0] d);
    chk({tag, "_cyc_up"}, 32'(cyc_o), 32'h1);
    repeat (ws) tick();
    ack_i = a; err_i = e; rty_i = r; dat_i = d;
    tick();
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'h0;
    chk({tag, "_cyc_drop"}, 32'(cyc_o), 32'h0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cyc", 32'(cyc_o), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_ni = 1'b1;
    tick();

    // Write 0xDEADBEEF to 0x10000010, acked after two wait states.
    send_cmd(8'h02, 32'h1000_0010);
    chk("wr_busy", 32'(busy_o), 32'h1);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    chk("wr_stb", 32'(stb_o), 32'h1);
    chk("wr_adr", adr_o, 32'h1000_0010);
    chk("wr_dat", dat_o, 32'hDEAD_BEEF);
    chk("wr_we", 32'(we_o), 32'h1);
    chk("wr_sel", 32'(sel_o), 32'hF);
    chk("wr_rx_ready_bus", 32'(rx_ready_o), 32'h0);
    bus_term("wr", 2, 1'b1, 1'b0, 1'b0, 32'h0);
    recv_byte("wr_status", 8'h00);
    chk("wr_done_tx_valid", 32'(tx_valid_o), 32'h0);
    tick();
    chk("wr_done_busy", 32'(busy_o), 32'h0);

    // Read of 0x40 returning 1.
    send_cmd(8'h01, 32'h0000_0040);
    chk("rd_adr", adr_o, 32'h0000_0040);
    chk("rd_we", 32'(we_o), 32'h0);
    bus_term("rd", 0, 1'b1, 1'b0, 1'b0, 32'h0000_0001);
    chk("rd_we_after", 32'(we_o), 32'h0);
    recv_byte("rd_status", 8'h00);
    recv_byte("rd_b0", 8'h01);
    recv_byte("rd_b1", 8'h00);
    recv_byte("rd_b2", 8'h00);
    recv_byte("rd_b3", 8'h00);
    chk("rd_done_tx_valid", 32'(tx_valid_o), 32'h0);

    // err and ack together: error wins, no data bytes follow.
    send_cmd(8'h01, 32'h0000_0044);
    bus_term("ea", 0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
    recv_byte("ea_status", 8'h01);
    chk("ea_no_data", 32'(tx_valid_o), 32'h0);
    tick();
    chk("ea_idle", 32'(busy_o), 32'h0);

    send_cmd(8'h01, 32'h0000_0048);
    bus_term("rd2", 1, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    recv_byte("rd2_status", 8'h00);
    recv_byte("rd2_b0", 8'h78);
    recv_byte("rd2_b1", 8'h56);
    recv_byte("rd2_b2", 8'h34);
    recv_byte("rd2_b3", 8'h12);

    // ack outranks rty; rty alone reports 02.
    send_cmd(8'h01, 32'h0000_004C);
    bus_term("ar", 0, 1'b1, 1'b0, 1'b1, 32'h0000_00C3);
    recv_byte("ar_status", 8'h00);
    recv_byte("ar_b0", 8'hC3);
    recv_byte("ar_b1", 8'h00);
    recv_byte("ar_b2", 8'h00);
    recv_byte("ar_b3", 8'h00);
    send_cmd(8'h01, 32'h0000_0050);
    bus_term("rty", 0, 1'b0, 1'b0, 1'b1, 32'h0);
    recv_byte("rty_status", 8'h02);
    chk("rty_no_data", 32'(tx_valid_o), 32'h0);

    // Timeout with no slave response: cyc_o high for exactly 8 cycles.
    send_cmd(8'h01, 32'h0000_0080);
    n = 0;
    while (cyc_o && n < 50) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd8);
    recv_byte("tmo_status", 8'h03);
    chk("tmo_no_data", 32'(tx_valid_o), 32'h0);

    // ack in the final timeout cycle wins.
    send_cmd(8'h01, 32'h0000_0084);
    bus_term("tmo_ack", 7, 1'b1, 1'b0, 1'b0, 32'h0000_00A5);
    recv_byte("tmo_ack_status", 8'h00);
    recv_byte("tmo_ack_b0", 8'hA5);
    recv_byte("tmo_ack_b1", 8'h00);
    recv_byte("tmo_ack_b2", 8'h00);
    recv_byte("tmo_ack_b3", 8'h00);

    // Unknown byte is dropped without bus activity.
    send_byte(8'h7F);
    chk("unk_cyc", 32'(cyc_o), 32'h0);
    chk("unk_busy", 32'(busy_o), 32'h0);
    tick();
    chk("unk_busy2", 32'(busy_o), 32'h0);
    send_cmd(8'h01, 32'h0000_0090);
    chk("unk_rd_adr", adr_o, 32'h0000_0090);
    bus_term("unk_rd", 0, 1'b1, 1'b0, 1'b0, 32'h4433_2211);
    recv_byte("unk_status", 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(tx_valid_o), 32'h1);
      chk("stall_data", 32'(tx_data_o), 32'h11);
      tick();
    end
    recv_byte("unk_b0", 8'h11);
    recv_byte("unk_b1", 8'h22);
    recv_byte("unk_b2", 8'h33);
    recv_byte("unk_b3", 8'h44);

    // Asynchronous reset in the middle of a bus cycle.
    send_cmd(8'h02, 32'h0000_0100);
    for (int i = 0; i < 4; i++) send_byte(8'h55);
    chk("ar_cyc_before", 32'(cyc_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_cyc", 32'(cyc_o), 32'h0);
    chk("arst_stb", 32'(stb_o), 32'h0);
    chk("arst_tx_valid", 32'(tx_valid_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("arst_busy_after", 32'(busy_o), 32'h0);
    send_cmd(8'h02, 32'h0000_0200);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    chk("post_rst_adr", adr_o, 32'h0000_0200);
    chk("post_rst_dat", dat_o, 32'h0102_0304);
    chk("post_rst_we", 32'(we_o), 32'h1);
    bus_term("post_rst", 0, 1'b1, 1'b0, 1'b0, 32'h0);
    recv_byte("post_rst_status", 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/wb_debug_master.md
Name: wb_debug_master

Overview:
Byte-stream-to-Wishbone bridge that acts as a second bus initiator alongside the CPU. It lets a host read and write any slave (memory, GPIO) over a UART link.
- Consumes command bytes from a UART receiver through a valid/ready stream.
- Issues single Wishbone classic transfers.
- Returns status and read data as a byte stream to a UART transmitter.
- Sits behind a bus arbiter that shares the slave port with the CPU.

Parameters:
TIMEOUT_CYCLES, 1024, bus cycles to wait for ack/err/rty before abandoning a transfer; 0 disables the timeout.
CMD_READ, 8'h01, command byte for a read.
CMD_WRITE, 8'h02, command byte for a write.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
rx_data_i  input  8  command stream byte
rx_valid_i  input  1  rx_data_i valid
rx_ready_o  output  1  block accepts rx byte this cycle
tx_data_o  output  8  response stream byte
tx_valid_o  output  1  tx_data_o valid
tx_ready_i  input  1  sink accepts tx byte this cycle
cyc_o  output  1  Wishbone cycle
stb_o  output  1  Wishbone strobe
adr_o  output  32  Wishbone byte address
sel_o  output  4  byte selects, always 4'hF during a transfer
dat_o  output  32  write data
we_o  output  1  write enable
dat_i  input  32  read data
ack_i  input  1  normal termination
err_i  input  1  error termination
rty_i  input  1  retry termination
busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, all counters cleared. All outputs go to 0 immediately, including cyc_o and stb_o; a bus transfer in progress is aborted.
- Byte handshake: a byte transfers on a rising edge where valid && ready. tx_data_o must be held stable while tx_valid_o && !tx_ready_i.
- rx_ready_o is high only in IDLE, ADDR and WDATA. tx_valid_o is high only in RESP_STATUS and RESP_DATA.
- IDLE:
  - CMD_READ accepted -> ADDR with we=0.
  - CMD_WRITE accepted -> ADDR with we=1.
  - Any other byte is consumed and dropped; stay in IDLE.
- ADDR: accept 4 bytes, little-endian, into the address register (first byte = adr[7:0]).
  - After the 4th byte: write -> WDATA; read -> BUS.
- WDATA: accept 4 bytes, little-endian, into the data register. After the 4th byte -> BUS.
- BUS:
  - cyc_o = stb_o = 1, sel_o = 4'hF, we_o per command, adr_o/dat_o from registers.
  - cyc_o/stb_o rise on the clock edge that accepts the final command byte (first BUS cycle).
  - Signals are held constant until a termination is sampled.
  - Termination priority when several are high in one cycle: err_i > ack_i > rty_i. Status: ack=8'h00, err=8'h01, rty=8'h02.
  - On ack of a read, capture dat_i in the same cycle.
  - cyc_o/stb_o drop on the edge after the termination sample; state -> RESP_STATUS.
  - No automatic retry on rty_i.
- Timeout (TIMEOUT_CYCLES > 0):
  - A cycle counter clears on entry to BUS and increments each BUS cycle without termination.
  - When the count reaches TIMEOUT_CYCLES-1 with no termination: drop cyc/stb, status 8'h03, go to RESP_STATUS.
  - A termination in the same cycle as the timeout wins over the timeout.
- RESP_STATUS: present the status byte.
  - On handshake: read with status 00 -> RESP_DATA; otherwise -> IDLE.
- RESP_DATA: present 4 read-data bytes, little-endian; after the 4th handshake -> IDLE.
- Command bytes are only accepted again after return to IDLE. No pipelining; one transfer outstanding at most.
- busy_o is registered and tracks state != IDLE.

Test Plan:
- Write: bytes 02,10,00,00,10,EF,BE,AD,DE -> one cycle with adr_o=32'h1000_0010, dat_o=32'hDEADBEEF, we_o=1, sel_o=F; slave acks after 2 wait states -> tx 00; cyc_o low the cycle after ack.
- Read: bytes 01,00,00,00,40; slave returns dat_i=32'h0000_0001 with ack -> tx 00,01,00,00,00, we_o=0 throughout.
- err_i and ack_i high in the same cycle on a read -> tx 01 only, no data bytes; a following command executes normally.
- Timeout: TIMEOUT_CYCLES=8, no slave response -> cyc_o high exactly 8 cycles, then tx 03. Separately, ack in cycle 8 -> tx 00.
- Unknown byte 7F then a valid read -> 7F dropped with no bus activity; the read completes correctly. With tx_ready_i low for 5 cycles, tx_data_o stays stable.
- Assert rst_ni low while cyc_o high -> cyc_o, stb_o, tx_valid_o are 0 in the same cycle without waiting for a clock edge; after release busy_o=0 and a new write works.
